// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length header, LE 32-bit words, optional XOR checksum (IMEM_LOADER_CHECKSUM_EN).
// Latency: WE one cycle after a word's 4th byte is accepted; DONE/ERR one cycle after the deciding byte.
// Backpressure: never stalls mid-load (rx_ready=1 throughout LEN/DATA/CHECK); idle input cycles hold all state.
module imem_loader #(
    parameter int unsigned DEPTH     = 10001,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_OK,
        S_FAIL
    } state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] word_idx;
    logic [31:0] n_words;
    logic [23:0] asm_bytes;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xsum;
`endif

    logic        accept;
    logic [31:0] n_next;
    logic [31:0] word_next;
    logic        last_word;

    // Byte-level helpers: length and data words are shifted in little-endian
    assign accept    = rx_valid && rx_ready;
    assign n_next    = {rx_data, n_words[31:8]};
    assign word_next = {rx_data, asm_bytes};
    assign last_word = (word_idx == n_words - 32'd1);

    // Load sequencer with registered handshake, write port and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            byte_cnt  <= 2'd0;
            word_idx  <= 32'd0;
            n_words   <= 32'd0;
            asm_bytes <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum      <= 8'd0;
`endif
            rx_ready  <= 1'b0;
            we        <= 1'b0;
            wa        <= 32'd0;
            wd        <= 32'd0;
            core_rst  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            we <= 1'b0;
            case (state)
                S_IDLE, S_OK, S_FAIL: begin
                    if (start) begin
                        state    <= S_LEN;
                        byte_cnt <= 2'd0;
                        word_idx <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum     <= 8'd0;
`endif
                        done     <= 1'b0;
                        err      <= 1'b0;
                        core_rst <= 1'b1;
                        busy     <= 1'b1;
                        rx_ready <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        n_words  <= n_next;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum     <= xsum ^ rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            if (n_next > DEPTH) begin
                                state    <= S_FAIL;
                                err      <= 1'b1;
                                busy     <= 1'b0;
                                rx_ready <= 1'b0;
                            end else if (n_next == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state    <= S_CHECK;
`else
                                state    <= S_OK;
                                done     <= 1'b1;
                                core_rst <= 1'b0;
                                busy     <= 1'b0;
                                rx_ready <= 1'b0;
`endif
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        asm_bytes <= {rx_data, asm_bytes[23:8]};
                        byte_cnt  <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum      <= xsum ^ rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            we       <= 1'b1;
                            wa       <= BASE_ADDR + {word_idx[29:0], 2'b00};
                            wd       <= word_next;
                            word_idx <= word_idx + 32'd1;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state    <= S_CHECK;
`else
                                state    <= S_OK;
                                done     <= 1'b1;
                                core_rst <= 1'b0;
                                busy     <= 1'b0;
                                rx_ready <= 1'b0;
`endif
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        busy     <= 1'b0;
                        rx_ready <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        if (rx_data == xsum) begin
                            state    <= S_OK;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state <= S_FAIL;
                            err   <= 1'b1;
                        end
`else
                        // Unreachable without checksum support
                        state <= S_FAIL;
                        err   <= 1'b1;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, length overflow, bad checksum, empty image, gaps, mid-load reset.
// Latency: checks outputs 1 time unit after the active edge; writes are logged at the falling edge.
// Backpressure: input stream is driven only while rx_ready is expected high.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx[$];
    logic [31:0] wa_log[$];
    logic [31:0] wd_log[$];
    logic        done_log[$];

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic CSUM = 1'b1;
`else
    localparam logic CSUM = 1'b0;
`endif

    imem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every write (and DONE alongside it) mid-cycle
    always @(negedge clk) begin
        if (we) begin
            wa_log.push_back(wa);
            wd_log.push_back(wd);
            done_log.push_back(done);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_log.delete();
        wd_log.delete();
        done_log.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        clear_log();
    endtask

    // Stream tx[]; with gap=1 an idle cycle follows each byte, and start pulses in the gap after byte start_at
    task automatic send_tx(input bit gap, input int start_at);
        foreach (tx[i]) begin
            rx_data  = tx[i];
            rx_valid = 1'b1;
            @(posedge clk); #1;
            if (gap) begin
                rx_valid = 1'b0;
                if (i == start_at) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({pfx, "_we"},       {31'd0, we},       32'd0);
        check({pfx, "_wa"},       wa,                32'd0);
        check({pfx, "_wd"},       wd,                32'd0);
        check({pfx, "_core_rst"}, {31'd0, core_rst}, 32'd1);
        check({pfx, "_busy"},     {31'd0, busy},     32'd0);
        check({pfx, "_done"},     {31'd0, done},     32'd0);
        check({pfx, "_err"},      {31'd0, err},      32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-word image
        pulse_start();
        check("t1_busy",     {31'd0, busy},     32'd1);
        check("t1_rx_ready", {31'd0, rx_ready}, 32'd1);
        tx = '{8'h02, 8'h00, 8'h00, 8'h00,
               8'h13, 8'h01, 8'h50, 8'h00,
               8'h93, 8'h01, 8'hC0, 8'h00};
        if (CSUM) tx.push_back(8'h12);
        send_tx(1'b0, -1);
        check("t1_done",     {31'd0, done},     32'd1);
        check("t1_err",      {31'd0, err},      32'd0);
        check("t1_core_rst", {31'd0, core_rst}, 32'd0);
        check("t1_busy_end", {31'd0, busy},     32'd0);
        settle();
        check("t1_nwrites", wa_log.size(), 32'd2);
        if (wa_log.size() == 2) begin
            check("t1_wa0", wa_log[0], 32'h0000_0000);
            check("t1_wd0", wd_log[0], 32'h0050_0113);
            check("t1_wa1", wa_log[1], 32'h0000_0004);
            check("t1_wd1", wd_log[1], 32'h00C0_0193);
            check("t1_done_with_last_we", {31'd0, done_log[1]}, {31'd0, ~CSUM});
        end

        // Length overflow: N = 10210
        pulse_start();
        check("t2_done_cleared", {31'd0, done}, 32'd0);
        tx = '{8'hE2, 8'h27, 8'h00, 8'h00};
        send_tx(1'b0, -1);
        check("t2_err",      {31'd0, err},      32'd1);
        check("t2_done",     {31'd0, done},     32'd0);
        check("t2_core_rst", {31'd0, core_rst}, 32'd1);
        check("t2_rx_ready", {31'd0, rx_ready}, 32'd0);
        settle();
        check("t2_nwrites", wa_log.size(), 32'd0);

        // One word; checksum off by one (correct would be 0x23)
        pulse_start();
        check("t3_err_cleared", {31'd0, err}, 32'd0);
        tx = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        if (CSUM) tx.push_back(8'h22);
        send_tx(1'b0, -1);
        check("t3_err",      {31'd0, err},      {31'd0, CSUM});
        check("t3_done",     {31'd0, done},     {31'd0, ~CSUM});
        check("t3_core_rst", {31'd0, core_rst}, {31'd0, CSUM});
        settle();
        check("t3_nwrites", wa_log.size(), 32'd1);
        if (wa_log.size() == 1) begin
            check("t3_wa0", wa_log[0], 32'h0000_0000);
            check("t3_wd0", wd_log[0], 32'hDEAD_BEEF);
        end

        // Empty image
        pulse_start();
        tx = '{8'h00, 8'h00, 8'h00, 8'h00};
        if (CSUM) tx.push_back(8'h00);
        send_tx(1'b0, -1);
        check("t4_done",     {31'd0, done},     32'd1);
        check("t4_err",      {31'd0, err},      32'd0);
        check("t4_core_rst", {31'd0, core_rst}, 32'd0);
        settle();
        check("t4_nwrites", wa_log.size(), 32'd0);

        // Three words with idle cycles between bytes and a START mid-load
        pulse_start();
        tx = '{8'h03, 8'h00, 8'h00, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'hFF,
               8'h78, 8'h56, 8'h34, 8'h12};
        if (CSUM) tx.push_back(8'h18);
        send_tx(1'b1, 6);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_err",  {31'd0, err},  32'd0);
        settle();
        check("t5_nwrites", wa_log.size(), 32'd3);
        if (wa_log.size() == 3) begin
            check("t5_wa0", wa_log[0], 32'h0000_0000);
            check("t5_wd0", wd_log[0], 32'h0000_0013);
            check("t5_wa1", wa_log[1], 32'h0000_0004);
            check("t5_wd1", wd_log[1], 32'hFFFF_FFFF);
            check("t5_wa2", wa_log[2], 32'h0000_0008);
            check("t5_wd2", wd_log[2], 32'h1234_5678);
        end

        // Reset in place of word 1's final byte
        pulse_start();
        tx = '{8'h02, 8'h00, 8'h00, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77};
        send_tx(1'b0, -1);
        rx_data  = 8'h88;
        rx_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        rx_valid = 1'b0;
        check_reset_values("t6");
        settle();
        check("t6_nwrites", wa_log.size(), 32'd1);
        if (wa_log.size() == 1)
            check("t6_wd0", wd_log[0], 32'h4433_2211);

        // Fresh load after the abort
        pulse_start();
        tx = '{8'h02, 8'h00, 8'h00, 8'h00,
               8'h13, 8'h01, 8'h50, 8'h00,
               8'h93, 8'h01, 8'hC0, 8'h00};
        if (CSUM) tx.push_back(8'h12);
        send_tx(1'b0, -1);
        check("t7_done", {31'd0, done}, 32'd1);
        settle();
        check("t7_nwrites", wa_log.size(), 32'd2);
        if (wa_log.size() == 2)
            check("t7_wd1", wd_log[1], 32'h00C0_0193);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
